// File: rtl/wb_servo_ramp_pkg.sv
// wb_servo_ramp shared definitions: register map, field widths, clamp helper.
// Optional interrupt support is selected in the top by WB_SERVO_IRQ_EN.
package wb_servo_ramp_pkg;

  localparam int N_CH = 8;
  localparam int PW_W = 12;
  localparam int FC_W = 15;

  localparam logic [6:0] REG_CTRL         = 7'h00;
  localparam logic [6:0] REG_STATUS       = 7'h04;
  localparam logic [6:0] REG_SLEW         = 7'h08;
  localparam logic [6:0] REG_IRQMASK      = 7'h0C;
  localparam logic [6:0] REG_TARGET_BASE  = 7'h20;
  localparam logic [6:0] REG_CURRENT_BASE = 7'h40;

  function automatic logic [PW_W-1:0] clamp_us(
    input logic [PW_W-1:0] v,
    input logic [PW_W-1:0] lo,
    input logic [PW_W-1:0] hi
  );
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

endpackage

// File: rtl/wb_servo_ramp_channel.sv
// servo_channel: one PWM channel holding TARGET/CURRENT, the per-frame
// slew step and the pulse compare.
module servo_channel
  import wb_servo_ramp_pkg::*;
#(
  parameter int min_us = 500,
  parameter int max_us = 2500
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            frame_start,
  input  logic            en,
  input  logic [PW_W-1:0] slew,
  input  logic            wr,
  input  logic [PW_W-1:0] wdata,
  input  logic [FC_W-1:0] frame_cnt,
  output logic [PW_W-1:0] target,
  output logic [PW_W-1:0] current,
  output logic            busy,
  output logic            pwm
);

  localparam logic [PW_W-1:0] MIN = PW_W'(min_us);
  localparam logic [PW_W-1:0] MAX = PW_W'(max_us);
  localparam logic [PW_W-1:0] CTR = PW_W'((min_us + max_us) / 2);

  logic               en_lat;
  logic signed [12:0] d;
  logic [12:0]        mag;
  logic [PW_W-1:0]    nxt;

  always_comb begin
    d   = $signed({1'b0, target}) - $signed({1'b0, current});
    mag = d[12] ? 13'(-d) : 13'(d);
    nxt = target;
    if (slew != '0 && mag > {1'b0, slew}) begin
      nxt = d[12] ? current - slew : current + slew;
    end
  end

  // en_lat and CURRENT move only at frame start so pulses never glitch
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      target  <= CTR;
      current <= CTR;
      en_lat  <= 1'b0;
    end else begin
      if (frame_start) begin
        en_lat  <= en;
        current <= nxt;
      end
      if (wr) target <= clamp_us(wdata, MIN, MAX);
    end
  end

  assign busy = target != current;
  assign pwm  = en_lat & (frame_cnt < {{(FC_W-PW_W){1'b0}}, current});

endmodule

// File: rtl/wb_servo_ramp.sv
// wb_servo_ramp: Wishbone slave driving 8 slewed servo PWM outputs.
// Define WB_SERVO_IRQ_EN to add the irq port, IRQMASK and done flags.
module wb_servo_ramp
  import wb_servo_ramp_pkg::*;
#(
  parameter int clk_freq  = 100000000,
  parameter int period_us = 20000,
  parameter int min_us    = 500,
  parameter int max_us    = 2500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic [3:0]  wb_sel_i,
  output logic        wb_ack_o,
`ifdef WB_SERVO_IRQ_EN
  output logic        irq,
`endif
  output logic        pwm0,
  output logic        pwm1,
  output logic        pwm2,
  output logic        pwm3,
  output logic        pwm4,
  output logic        pwm5,
  output logic        pwm6,
  output logic        pwm7
);

  localparam int PRE  = clk_freq / 1000000;
  localparam int PS_W = (PRE > 1) ? $clog2(PRE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRE - 1);
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(period_us - 1);

  logic [PS_W-1:0] ps_cnt;
  logic [FC_W-1:0] frame_cnt;
  logic            tick;
  logic            frame_start;

  assign tick        = ps_cnt == PS_LAST;
  assign frame_start = tick && (frame_cnt == FC_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ps_cnt    <= '0;
      frame_cnt <= '0;
    end else begin
      ps_cnt <= tick ? '0 : ps_cnt + 1'b1;
      if (tick) frame_cnt <= frame_start ? '0 : frame_cnt + 1'b1;
    end
  end

  logic       req;
  logic       wr;
  logic [6:0] reg_a;
  logic [2:0] ch;
  logic       sel_ctrl;
  logic       sel_status;
  logic       sel_slew;
  logic       sel_mask;
  logic       sel_tgt;
  logic       sel_cur;

  assign req        = wb_cyc_i & wb_stb_i;
  assign wr         = req & wb_we_i & wb_ack_o;
  assign reg_a      = {wb_adr_i[6:2], 2'b00};
  assign ch         = wb_adr_i[4:2];
  assign sel_ctrl   = reg_a == REG_CTRL;
  assign sel_status = reg_a == REG_STATUS;
  assign sel_slew   = reg_a == REG_SLEW;
  assign sel_mask   = reg_a == REG_IRQMASK;
  assign sel_tgt    = reg_a[6:5] == REG_TARGET_BASE[6:5];
  assign sel_cur    = reg_a[6:5] == REG_CURRENT_BASE[6:5];

  logic            unused_ok;
  assign unused_ok = ^{wb_sel_i, wb_adr_i[31:7], wb_adr_i[1:0],
                       wb_dat_i[31:12]};

  logic [7:0]      ctrl;
  logic [PW_W-1:0] slew;
  logic            wrap;
  logic [7:0]      done;
  logic [7:0]      irqmask;
  logic [N_CH-1:0] busy;
  logic [N_CH-1:0] pwm_v;
  logic [PW_W-1:0] target  [N_CH];
  logic [PW_W-1:0] current [N_CH];
  logic [31:0]     rdata;

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    servo_channel #(
      .min_us (min_us),
      .max_us (max_us)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .frame_start (frame_start),
      .en          (ctrl[k]),
      .slew        (slew),
      .wr          (wr & sel_tgt & (ch == 3'(k))),
      .wdata       (wb_dat_i[PW_W-1:0]),
      .frame_cnt   (frame_cnt),
      .target      (target[k]),
      .current     (current[k]),
      .busy        (busy[k]),
      .pwm         (pwm_v[k])
    );
  end

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      sel_ctrl:   rdata[7:0]      = ctrl;
      sel_status: rdata           = {8'h00, done, 7'h00, wrap, busy};
      sel_slew:   rdata[PW_W-1:0] = slew;
      sel_mask:   rdata[7:0]      = irqmask;
      sel_tgt:    rdata[PW_W-1:0] = target[ch];
      sel_cur:    rdata[PW_W-1:0] = current[ch];
      default:    rdata           = '0;
    endcase
  end

  // frame-wrap set wins over a same-cycle clear so no wrap is lost
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
      ctrl     <= '0;
      slew     <= '0;
      wrap     <= 1'b0;
    end else begin
      wb_ack_o <= req & ~wb_ack_o;
      wb_dat_o <= (req & ~wb_ack_o) ? rdata : '0;
      if (wr & sel_ctrl) ctrl <= wb_dat_i[7:0];
      if (wr & sel_slew) slew <= wb_dat_i[PW_W-1:0];
      wrap <= frame_start | (wrap & ~(wr & sel_status & wb_dat_i[8]));
    end
  end

`ifdef WB_SERVO_IRQ_EN
  logic [7:0] busy_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irqmask <= '0;
      done    <= '0;
      busy_q  <= '0;
    end else begin
      busy_q <= busy;
      if (wr & sel_mask) irqmask <= wb_dat_i[7:0];
      done <= (done & ~({8{wr & sel_status}} & wb_dat_i[23:16]))
            | (busy_q & ~busy);
    end
  end

  assign irq = |(done & irqmask);
`else
  assign done    = '0;
  assign irqmask = '0;
`endif

  assign pwm0 = pwm_v[0];
  assign pwm1 = pwm_v[1];
  assign pwm2 = pwm_v[2];
  assign pwm3 = pwm_v[3];
  assign pwm4 = pwm_v[4];
  assign pwm5 = pwm_v[5];
  assign pwm6 = pwm_v[6];
  assign pwm7 = pwm_v[7];

endmodule
